// File: rtl/pixel_stream_pkg.sv
// Shared constants, FSM state type and lane-unpack helper for the pixel band streamer.
package pixel_stream_pkg;

    localparam int IMG_W  = 20;
    localparam int IMG_H  = 20;
    localparam int LANES  = 5;
    localparam int PIX_W  = 5;
    localparam int ADDR_W = 7;
    localparam int BEATS  = IMG_W * IMG_H / LANES;
    localparam int WORD_W = LANES * PIX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

    // Pick lane k out of a packed SRAM word (lane k sits at bits [k*PIX_W +: PIX_W]).
    function automatic logic [PIX_W-1:0] lane_pix(input logic [WORD_W-1:0] word,
                                                  input int unsigned k);
        return word[k*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// 2-entry skid FIFO that catches SRAM read data; the head falls through
// combinationally when empty so an arriving word can be consumed the same cycle.
module stream_skid_fifo
    import pixel_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              head_vld,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              store;
    logic              take;

    // A push that is popped straight through while empty never lands in storage.
    assign store    = push && !(empty && pop);
    assign take     = pop && !empty;
    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign head_vld = !empty || push;
    assign rdata    = empty ? wdata : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) wr_ptr <= ~wr_ptr;
            if (take)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pixel_band_streamer.sv
// Streams a 20x20 frame from packed SRAM as 5 parallel row lanes per beat,
// band by band and column by column, with downstream hold support.
// Optional checksum output enabled by defining STREAM_CSUM_EN.
module pixel_band_streamer
    import pixel_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              hold,
    output logic              out_valid,
    output logic [PIX_W-1:0]  pixel_out0,
    output logic [PIX_W-1:0]  pixel_out1,
    output logic [PIX_W-1:0]  pixel_out2,
    output logic [PIX_W-1:0]  pixel_out3,
    output logic [PIX_W-1:0]  pixel_out4,
`ifdef STREAM_CSUM_EN
    output logic              load_end,
    output logic [15:0]       csum
`else
    output logic              load_end
`endif
);

    stream_state_t     state;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] ld_cnt;
    logic              rvld_p1;
    logic [WORD_W-1:0] out_word_p2;

    logic [WORD_W-1:0] head_word;
    logic              head_vld;
    logic [1:0]        occ;
    logic              fifo_full;
    logic              fifo_empty;

    logic              consume;
    logic              load;
    logic [2:0]        pend;
    logic              issue;

    assign consume = out_valid && !hold;
    assign load    = head_vld && (!out_valid || !hold);

    // Words the FIFO will hold or still receive after this edge, before any new read.
    assign pend  = 3'(occ) + 3'(rvld_p1) + 3'(mem_rd) - 3'(load);
    assign issue = (state == STREAM) && (rd_cnt < ADDR_W'(BEATS)) && (pend < 3'd2);

    stream_skid_fifo u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (rvld_p1),
        .pop      (load),
        .wdata    (mem_rdata),
        .rdata    (head_word),
        .head_vld (head_vld),
        .count    (occ),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Frame sequencing: IDLE -> STREAM -> DONE (one-cycle done pulse) -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (consume && load_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM read issue, read counter and read-valid pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_cnt   <= '0;
            rvld_p1  <= 1'b0;
        end else begin
            rvld_p1 <= mem_rd;
            mem_rd  <= issue;
            if (state == IDLE && start) begin
                rd_cnt <= '0;
            end else if (issue) begin
                mem_addr <= rd_cnt;
                rd_cnt   <= rd_cnt + 1'b1;
            end
        end
    end

    // Output beat control: load from FIFO head when empty or when the current beat is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            load_end  <= 1'b0;
            ld_cnt    <= '0;
        end else begin
            if (state == IDLE && start) begin
                ld_cnt <= '0;
            end else if (load) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                load_end  <= (ld_cnt == ADDR_W'(BEATS - 1));
            end else if (consume) begin
                out_valid <= 1'b0;
                load_end  <= 1'b0;
            end
        end
    end

    // Output beat data; only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (load) out_word_p2 <= head_word;
    end

    assign pixel_out0 = out_valid ? lane_pix(out_word_p2, 0) : '0;
    assign pixel_out1 = out_valid ? lane_pix(out_word_p2, 1) : '0;
    assign pixel_out2 = out_valid ? lane_pix(out_word_p2, 2) : '0;
    assign pixel_out3 = out_valid ? lane_pix(out_word_p2, 3) : '0;
    assign pixel_out4 = out_valid ? lane_pix(out_word_p2, 4) : '0;

`ifdef STREAM_CSUM_EN
    logic [15:0] beat_sum;

    // Sum of the five pixels in the beat currently presented.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + 16'(lane_pix(out_word_p2, k));
        end
    end

    // Running modulo-2^16 pixel sum over consumed beats, cleared on accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (consume) begin
            csum <= csum + beat_sum;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_band_streamer.sv
// Scoreboard bench for pixel_band_streamer: SRAM model, randomized hold driver,
// expected beats queued at start and popped by an independent negedge monitor.
module tb_pixel_band_streamer;
    import pixel_stream_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic              busy, done, mem_rd, out_valid, load_end;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic [PIX_W-1:0]  pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4;
`ifdef STREAM_CSUM_EN
    logic [15:0]       csum;
`endif

    always #5 clk = ~clk;

    pixel_band_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .hold       (hold),
        .out_valid  (out_valid),
        .pixel_out0 (pixel_out0),
        .pixel_out1 (pixel_out1),
        .pixel_out2 (pixel_out2),
        .pixel_out3 (pixel_out3),
`ifdef STREAM_CSUM_EN
        .pixel_out4 (pixel_out4),
        .load_end   (load_end),
        .csum       (csum)
`else
        .pixel_out4 (pixel_out4),
        .load_end   (load_end)
`endif
    );

    typedef struct {
        logic [WORD_W-1:0] word;
        logic              last;
    } beat_t;

    logic [WORD_W-1:0] mem [BEATS];
    beat_t             exp_q [$];
    int                tests = 0;
    int                fails = 0;
    int                reads_total = 0;
    int                consumed_total = 0;
    int                io_base = 0;
    int                frame_base = 0;
    int                max_occ = 0;
    int                occ;
    int                hold_mode = 0;
    int                hold_left = 4;
    int                exp_csum = 0;
    bit                exp_done = 1'b0;
    bit                ok;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM model: registered read, data valid the cycle after mem_rd is sampled.
    always @(posedge clk) begin
        if (mem_rd) begin
            reads_total <= reads_total + 1;
            if (int'(mem_addr) < BEATS) mem_rdata <= mem[mem_addr];
        end
    end

    // Downstream hold driver.
    always @(posedge clk) begin
        #1;
        case (hold_mode)
            1: begin
                if (out_valid && (consumed_total - frame_base == 10) && hold_left > 0) begin
                    hold = 1'b1;
                    hold_left--;
                end else begin
                    hold = 1'b0;
                end
            end
            2: hold = ($urandom_range(0, 99) < 30);
            default: hold = 1'b0;
        endcase
        if (hold_mode != 1) hold_left = 4;
    end

    // Monitor: compare presented beats against the scoreboard, track done and outstanding reads.
    always @(negedge clk) begin
        if (reset) begin
            check("done", done, int'(exp_done));
`ifdef STREAM_CSUM_EN
            if (exp_done) check("csum_at_done", csum, exp_csum);
`endif
            exp_done = 1'b0;
            occ = (reads_total - consumed_total) - io_base + int'(mem_rd) - int'(out_valid);
            if (occ > max_occ) max_occ = occ;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("beat_queue_nonempty", exp_q.size(), 1);
                end else begin
                    check("beat_data",
                          {pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0},
                          exp_q[0].word);
                    check("load_end", load_end, int'(exp_q[0].last));
                    if (!hold) begin
                        if (exp_q[0].last) exp_done = 1'b1;
                        void'(exp_q.pop_front());
                        consumed_total++;
                    end
                end
            end else begin
                check("idle_lanes_zero",
                      {load_end, pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0}, 0);
            end
        end
    end

    task automatic fill_pattern();
        logic [4:0] v;
        for (int i = 0; i < BEATS; i++) begin
            v = 5'(i);
            mem[i] = {5{v}};
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < BEATS; i++) mem[i] = WORD_W'($urandom);
    endtask

    task automatic fill_const(input logic [4:0] v);
        for (int i = 0; i < BEATS; i++) mem[i] = {5{v}};
    endtask

    task automatic start_frame();
        beat_t b;
        int    s;
        s = 0;
        for (int i = 0; i < BEATS; i++) begin
            b.word = mem[i];
            b.last = (i == BEATS - 1);
            exp_q.push_back(b);
            for (int k = 0; k < LANES; k++) s += int'(mem[i][k*PIX_W +: PIX_W]);
        end
        exp_csum   = s % 65536;
        frame_base = consumed_total;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (consumed_total - frame_base >= n) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("beat_wait_timeout", 0, 1);
    endtask

    task automatic frame_checks();
        check("frame_beats", consumed_total - frame_base, BEATS);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1 check("busy_after_done", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_lanes"},
              {load_end, pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0}, 0);
    endtask

    initial begin
        int run;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full frame, no hold: latency and back-to-back beats
        fill_pattern();
        hold_mode = 0;
        start_frame();
        check("lat_c0", out_valid, 0);
        check("busy_on_start", busy, 1);
        @(posedge clk);
        #1 check("lat_c1", out_valid, 0);
        check("mem_rd_c1", mem_rd, 1);
        check("mem_addr_c1", mem_addr, 0);
        @(posedge clk);
        #1 check("lat_c2", out_valid, 0);
        run = 0;
        for (int i = 0; i < BEATS; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) run++;
        end
        check("valid_run", run, BEATS);
        wait_done(ok);
        frame_checks();

        // Hold for 4 cycles at beat 10
        hold_mode = 1;
        start_frame();
        wait_done(ok);
        frame_checks();
        hold_mode = 0;

        // Random 30% hold over random pixel data
        fill_random();
        hold_mode = 2;
        start_frame();
        wait_done(ok);
        frame_checks();
        hold_mode = 0;

        // Reset mid-frame at beat 40, then restart from address 0
        fill_random();
        start_frame();
        wait_beats(40);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        exp_q.delete();
        repeat (3) @(posedge clk);
        io_base = reads_total - consumed_total;
        #2 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("abort_idle", busy, 0);
        fill_random();
        hold_mode = 2;
        start_frame();
        wait_done(ok);
        frame_checks();
        hold_mode = 0;

        // start while busy and in the done cycle is ignored
        fill_pattern();
        start_frame();
        wait_beats(20);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(ok);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("ignored_start_beats", consumed_total - frame_base, BEATS);
        check("ignored_start_busy", busy, 0);
        check("ignored_start_queue", exp_q.size(), 0);

`ifdef STREAM_CSUM_EN
        // Checksum with all pixels at full scale
        fill_const(5'd31);
        hold_mode = 2;
        start_frame();
        wait_done(ok);
        check("csum_all31", csum, 12400);
        hold_mode = 0;
        repeat (4) @(posedge clk);
        #1 check("csum_held", csum, 12400);
`endif

        check("max_outstanding_le2", int'(max_occ <= 2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
